lc3_control_fsm: RTL and testbench

- Moore-style control FSM that sequences the LC-3 16-bit datapath through fetch, decode and execute.
- Drives every gate, load and mux-select input of the datapath, plus the active-low SRAM strobes.
- Implements ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE, with a parameterised memory wait.

---
 rtl/lc3_control_fsm.sv | 183 ++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: Moore LC-3 fetch/decode/execute sequencer; inputs clk, reset, Run, Continue, Opcode, IR_5, IR_11, BEN; outputs datapath gates, loads, mux selects and active-low SRAM strobes
module lc3_control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       GateMARMUX,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GatePC,
  output logic       LD_REG,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_IR,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       MARMUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic [1:0] PCMUX,
  output logic [1:0] DRMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] SR1MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_OE,
  output logic       Mem_WE
);
  typedef enum logic [4:0] {
    HALTED, F1, F2, F3, DEC, EX_ADD, EX_AND, EX_NOT, BR1, BR2, JMP,
    J1, J2, J3, L1, L2, L3, S1, S2, S3, P1, P2
  } state_t;
  state_t state, next;
  logic [3:0] cnt;
  logic mem_done, waiting, unused;
  assign unused = IR_5;
  assign waiting = state == F2 || state == L2 || state == S3;
  assign mem_done = cnt == 4'(MEM_WAIT - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HALTED;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= (waiting && next == state) ? cnt + 4'd1 : 4'd0;
    end
  end
  always_comb begin
    next = state;
    case (state)
      HALTED: next = Run ? F1 : HALTED;
      F1: next = F2;
      F2: next = mem_done ? F3 : F2;
      F3: next = DEC;
      DEC:
        case (Opcode)
          4'b0001: next = EX_ADD;
          4'b0101: next = EX_AND;
          4'b1001: next = EX_NOT;
          4'b0000: next = BR1;
          4'b1100: next = JMP;
          4'b0100: next = J1;
          4'b0110: next = L1;
          4'b0111: next = S1;
          4'b1101: next = P1;
          default: next = F1;
        endcase
      BR1: next = BEN ? BR2 : F1;
      J1: next = IR_11 ? J2 : J3;
      L1: next = L2;
      L2: next = mem_done ? L3 : L2;
      S1: next = S2;
      S2: next = S3;
      S3: next = mem_done ? F1 : S3;
      P1: next = Continue ? P2 : P1;
      P2: next = Continue ? P2 : F1;
      default: next = F1;
    endcase
  end
  always_comb begin
    GateMARMUX = 1'b0;
    GateMDR = 1'b0;
    GateALU = 1'b0;
    GatePC = 1'b0;
    LD_REG = 1'b0;
    LD_BEN = 1'b0;
    LD_CC = 1'b0;
    LD_IR = 1'b0;
    LD_MAR = 1'b0;
    LD_MDR = 1'b0;
    LD_PC = 1'b0;
    LD_LED = 1'b0;
    MARMUX = 1'b0;
    ADDR1MUX = 1'b0;
    MIO_EN = 1'b0;
    PCMUX = 2'b00;
    DRMUX = 2'b00;
    ADDR2MUX = 2'b00;
    SR1MUX = 2'b00;
    ALUK = 2'b00;
    Mem_CE = 1'b1;
    Mem_OE = 1'b1;
    Mem_WE = 1'b1;
    case (state)
      F1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC = 1'b1;
      end
      F2, L2: begin
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        MIO_EN = 1'b1;
        LD_MDR = 1'b1;
      end
      F3: begin
        GateMDR = 1'b1;
        LD_IR = 1'b1;
      end
      DEC: LD_BEN = 1'b1;
      EX_ADD, EX_AND, EX_NOT: begin
        SR1MUX = 2'b01;
        GateALU = 1'b1;
        ALUK = state == EX_ADD ? 2'b00 : state == EX_AND ? 2'b01 : 2'b10;
        LD_REG = 1'b1;
        LD_CC = 1'b1;
      end
      BR2: begin
        ADDR2MUX = 2'b10;
        PCMUX = 2'b10;
        LD_PC = 1'b1;
      end
      JMP, J3: begin
        SR1MUX = 2'b01;
        ADDR1MUX = 1'b1;
        PCMUX = 2'b10;
        LD_PC = 1'b1;
      end
      J1: begin
        GatePC = 1'b1;
        DRMUX = 2'b01;
        LD_REG = 1'b1;
      end
      J2: begin
        ADDR2MUX = 2'b11;
        PCMUX = 2'b10;
        LD_PC = 1'b1;
      end
      L1, S1: begin
        SR1MUX = 2'b01;
        ADDR1MUX = 1'b1;
        ADDR2MUX = 2'b01;
        MARMUX = 1'b1;
        GateMARMUX = 1'b1;
        LD_MAR = 1'b1;
      end
      L3: begin
        GateMDR = 1'b1;
        LD_REG = 1'b1;
        LD_CC = 1'b1;
      end
      S2: begin
        ALUK = 2'b11;
        GateALU = 1'b1;
        LD_MDR = 1'b1;
      end
      S3: begin
        Mem_CE = 1'b0;
        Mem_WE = 1'b0;
      end
      P1: LD_LED = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: scoreboard bench running instruction streams on MEM_WAIT=1,2,3 instances against per-instruction control-word sequences
module tb_lc3_control_fsm;
  typedef struct packed {
    logic gmarmux, gmdr, galu, gpc;
    logic ld_reg, ld_ben, ld_cc, ld_ir, ld_mar, ld_mdr, ld_pc, ld_led;
    logic marmux, addr1mux, mio_en;
    logic [1:0] pcmux, drmux, addr2mux, sr1mux, aluk;
    logic ce_n, oe_n, we_n;
  } ctl_t;
  localparam logic [5:0] DIR [13] = '{
    6'b0001_00, 6'b0101_00, 6'b1001_00, 6'b0000_00, 6'b0000_10, 6'b1100_00, 6'b0100_01,
    6'b0100_00, 6'b0110_00, 6'b0111_00, 6'b1101_00, 6'b1111_00, 6'b0011_00
  };
  logic clk;
  logic rst_s [3];
  logic run_s [3];
  logic cont_s [3];
  logic [3:0] opc [3];
  logic ir5 [3];
  logic ir11 [3];
  logic ben [3];
  ctl_t act [3];
  ctl_t q [$];
  ctl_t e;
  logic mon;
  int cur;
  int checks = 0;
  int failures = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g
    logic [27:0] o;
    assign act[k] = o;
    lc3_control_fsm #(.MEM_WAIT(k + 1)) dut (
      .clk(clk), .reset(rst_s[k]), .Run(run_s[k]), .Continue(cont_s[k]), .Opcode(opc[k]),
      .IR_5(ir5[k]), .IR_11(ir11[k]), .BEN(ben[k]),
      .GateMARMUX(o[27]), .GateMDR(o[26]), .GateALU(o[25]), .GatePC(o[24]),
      .LD_REG(o[23]), .LD_BEN(o[22]), .LD_CC(o[21]), .LD_IR(o[20]),
      .LD_MAR(o[19]), .LD_MDR(o[18]), .LD_PC(o[17]), .LD_LED(o[16]),
      .MARMUX(o[15]), .ADDR1MUX(o[14]), .MIO_EN(o[13]),
      .PCMUX(o[12:11]), .DRMUX(o[10:9]), .ADDR2MUX(o[8:7]), .SR1MUX(o[6:5]), .ALUK(o[4:3]),
      .Mem_CE(o[2]), .Mem_OE(o[1]), .Mem_WE(o[0])
    );
  end
  function automatic ctl_t idle();
    ctl_t c;
    c = '0;
    c.ce_n = 1'b1;
    c.oe_n = 1'b1;
    c.we_n = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_f1();
    ctl_t c = idle();
    c.gpc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_rd();
    ctl_t c = idle();
    c.ce_n = 1'b0; c.oe_n = 1'b0; c.mio_en = 1'b1; c.ld_mdr = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_f3();
    ctl_t c = idle();
    c.gmdr = 1'b1; c.ld_ir = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_dec();
    ctl_t c = idle();
    c.ld_ben = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_alu(logic [1:0] k);
    ctl_t c = idle();
    c.sr1mux = 2'b01; c.galu = 1'b1; c.aluk = k; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_br2();
    ctl_t c = idle();
    c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_jreg();
    ctl_t c = idle();
    c.sr1mux = 2'b01; c.addr1mux = 1'b1; c.pcmux = 2'b10; c.ld_pc = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_j1();
    ctl_t c = idle();
    c.gpc = 1'b1; c.drmux = 2'b01; c.ld_reg = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_j2();
    ctl_t c = idle();
    c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_ea();
    ctl_t c = idle();
    c.sr1mux = 2'b01; c.addr1mux = 1'b1; c.addr2mux = 2'b01; c.marmux = 1'b1;
    c.gmarmux = 1'b1; c.ld_mar = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_l3();
    ctl_t c = idle();
    c.gmdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_s2();
    ctl_t c = idle();
    c.aluk = 2'b11; c.galu = 1'b1; c.ld_mdr = 1'b1;
    return c;
  endfunction
  function automatic ctl_t x_wr();
    ctl_t c = idle();
    c.ce_n = 1'b0; c.we_n = 1'b0;
    return c;
  endfunction
  function automatic ctl_t x_p1();
    ctl_t c = idle();
    c.ld_led = 1'b1;
    return c;
  endfunction
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push_fetch(int w);
    q.push_back(x_f1());
    repeat (w) q.push_back(x_rd());
    q.push_back(x_f3());
    q.push_back(x_dec());
  endtask
  task automatic run_one(int k, int w);
    cur = k;
    rst_s[k] = 1'b1;
    step(2);
    rst_s[k] = 1'b0;
    run_s[k] = 1'b0;
    repeat (5) q.push_back(idle());
    mon = 1'b1;
    step(5);
    run_s[k] = 1'b1;
    q.push_back(idle());
    step(1);
    for (int n = 0; n < 45; n++) begin
      logic [5:0] d;
      int h0, h1;
      d = n < 13 ? DIR[n] : 6'($urandom);
      h0 = n == 10 ? 10 : $urandom_range(0, 6);
      h1 = $urandom_range(1, 4);
      opc[k] = d[5:2];
      ben[k] = d[1];
      ir11[k] = d[0];
      ir5[k] = 1'($urandom);
      run_s[k] = 1'($urandom);
      push_fetch(w);
      case (d[5:2])
        4'b0001: q.push_back(x_alu(2'b00));
        4'b0101: q.push_back(x_alu(2'b01));
        4'b1001: q.push_back(x_alu(2'b10));
        4'b0000: begin
          q.push_back(idle());
          if (d[1]) q.push_back(x_br2());
        end
        4'b1100: q.push_back(x_jreg());
        4'b0100: begin
          q.push_back(x_j1());
          q.push_back(d[0] ? x_j2() : x_jreg());
        end
        4'b0110: begin
          q.push_back(x_ea());
          repeat (w) q.push_back(x_rd());
          q.push_back(x_l3());
        end
        4'b0111: begin
          q.push_back(x_ea());
          q.push_back(x_s2());
          repeat (w) q.push_back(x_wr());
        end
        4'b1101: begin
          repeat (h0 + 1) q.push_back(x_p1());
          repeat (h1) q.push_back(idle());
        end
        default: ;
      endcase
      if (d[5:2] == 4'b1101) begin
        step(q.size() - h0 - 1 - h1);
        step(h0);
        cont_s[k] = 1'b1;
        step(h1);
        cont_s[k] = 1'b0;
        step(1);
      end else step(q.size());
    end
    opc[k] = 4'b0111;
    push_fetch(w);
    q.push_back(x_ea());
    q.push_back(x_s2());
    repeat (w < 2 ? 1 : 2) q.push_back(x_wr());
    step(q.size() - 1);
    rst_s[k] = 1'b1;
    run_s[k] = 1'b1;
    step(1);
    q.push_back(idle());
    step(1);
    rst_s[k] = 1'b0;
    run_s[k] = 1'b0;
    q.push_back(idle());
    step(1);
    mon = 1'b0;
    rst_s[k] = 1'b1;
  endtask
  always @(negedge clk) begin
    if (mon) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL underflow w=%0d t=%0t got=%h required=none", cur + 1, $time, act[cur]);
      end else begin
        e = q.pop_front();
        if (act[cur] !== e) begin
          failures++;
          $display("FAIL ctl w=%0d t=%0t got=%h required=%h", cur + 1, $time, act[cur], e);
        end
      end
    end
  end
  initial begin
    mon = 1'b0;
    cur = 0;
    for (int k = 0; k < 3; k++) begin
      rst_s[k] = 1'b1;
      run_s[k] = 1'b0;
      cont_s[k] = 1'b0;
      opc[k] = 4'd0;
      ir5[k] = 1'b0;
      ir11[k] = 1'b0;
      ben[k] = 1'b0;
    end
    for (int k = 0; k < 3; k++) run_one(k, k + 1);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover got=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
